// File: rtl/fddi_claim_arb.sv
// Multi-channel FDDI claim front-end and lowest-index ownership arbiter.
// Optional forced release of a long-held owner is enabled by defining FDDI_CLAIM_TIMEOUT_EN.
module fddi_claim_arb #(
  parameter int NCH  = 4,
  parameter int TMAX = 16,
  parameter int CW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           merge,
  input  logic [NCH-1:0] er,
  input  logic [NCH-1:0] xmit,
  input  logic [NCH-1:0] fddi,
  output logic [NCH-1:0] claim,
  output logic [NCH-1:0] claim_win,
  output logic           busy,
  output logic           timeout
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, WON} state_t;

  state_t         state;
  logic [NCH-1:0] fcr;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  cand;
  logic [NCH-1:0] elig;
  logic           cand_vld;
  logic [IW-1:0]  cand_idx;

  function automatic logic [IW:0] pick_lowest(input logic [NCH-1:0] v);
    logic [IW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  // Stage 1 (fcr) and stage 2 (claim); merge uses the previous fcr value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcr   <= '0;
      claim <= '0;
    end else begin
      fcr   <= er | xmit;
      claim <= merge ? (fcr & fddi) : fddi;
    end
  end

`ifdef FDDI_CLAIM_TIMEOUT_EN
  logic [NCH-1:0] mask;
  logic           force_rel;

  // A natural release (claim dropped) takes precedence over a forced one
  assign force_rel = (state == WON) && claim[cand] && (cnt == CW'(TMAX - 1));
  assign elig      = claim & ~mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask <= '0;
    else     mask <= (mask & claim) | (force_rel ? (NCH'(1) << cand) : '0);
  end
`else
  assign elig = claim;
`endif

  assign {cand_vld, cand_idx} = pick_lowest(elig);

  // Arbitration stage: all outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      claim_win <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cand_vld) begin
            state <= HOLD;
            cand  <= cand_idx;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        HOLD: begin
          if (!cand_vld) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cand_idx != cand) begin
            cand <= cand_idx;
            cnt  <= CW'(1);
          end else if (cnt == CW'(TMAX - 1)) begin
            state     <= WON;
            claim_win <= NCH'(1) << cand;
            cnt       <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        WON: begin
          if (!claim[cand]) begin
            state     <= IDLE;
            claim_win <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
          end
`ifdef FDDI_CLAIM_TIMEOUT_EN
          else if (force_rel) begin
            state     <= IDLE;
            claim_win <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
`endif
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          claim_win <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
